mem_access_unit: RTL and testbench



---
 rtl/lc3b_types.sv | 27 ++
 rtl/mem_access_unit_byte_lane.sv | 22 ++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b memory-op and mem_access_unit state encodings
package lc3b_types;

    typedef enum logic [2:0] {
        MEMOP_LDW = 3'd0,
        MEMOP_LDB = 3'd1,
        MEMOP_STW = 3'd2,
        MEMOP_STB = 3'd3,
        MEMOP_LDI = 3'd4,
        MEMOP_STI = 3'd5
    } lc3b_memop;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IND_RD,
        ST_ACCESS,
        ST_DONE
    } mem_access_state_t;

    localparam logic [2:0] OP_LDW = 3'd0;
    localparam logic [2:0] OP_LDB = 3'd1;
    localparam logic [2:0] OP_STW = 3'd2;
    localparam logic [2:0] OP_STB = 3'd3;
    localparam logic [2:0] OP_LDI = 3'd4;
    localparam logic [2:0] OP_STI = 3'd5;

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// rtl/mem_access_unit_byte_lane.sv - byte_lane: lane extract/sign-extend, byte replicate, one-hot lane enable
module byte_lane #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]             i_rd_word,
    input  logic [$clog2(WIDTH/8)-1:0]   i_rd_lane,
    input  logic [7:0]                   i_wr_byte,
    input  logic [$clog2(WIDTH/8)-1:0]   i_wr_lane,
    output logic [WIDTH-1:0]             o_rd_sext,
    output logic [WIDTH-1:0]             o_wr_repl,
    output logic [WIDTH/8-1:0]           o_wr_be
);
    localparam int LANES = WIDTH / 8;

    logic [7:0] w_rd_byte;

    assign w_rd_byte = i_rd_word[{i_rd_lane, 3'b000} +: 8];
    assign o_rd_sext = {{(WIDTH-8){w_rd_byte[7]}}, w_rd_byte};
    assign o_wr_repl = {LANES{i_wr_byte}};
    assign o_wr_be   = {{(LANES-1){1'b0}}, 1'b1} << i_wr_lane;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle load/store engine; LDI/STI present when MEM_ACCESS_INDIRECT_EN is defined
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic [2:0]              req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]        req_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [WIDTH/8-1:0]      mem_byte_enable,
    output logic [WIDTH-1:0]        mem_wdata,
    input  logic [WIDTH-1:0]        mem_rdata,
    input  logic                    mem_resp
);
    localparam int LANES = WIDTH / 8;
    localparam int LW    = $clog2(LANES);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);
    localparam logic [LANES-1:0]      ALL_LANES = '1;

    mem_access_state_t      r_state, w_state_next;
    logic [2:0]             r_op, w_op_next;
    logic [LW-1:0]          r_lane, w_lane_next;
    logic                   r_busy, r_done;
    logic                   r_mem_read, w_mem_read_next;
    logic                   r_mem_write, w_mem_write_next;
    logic [ADDR_WIDTH-1:0]  r_mem_address, w_mem_address_next;
    logic [LANES-1:0]       r_mem_be, w_mem_be_next;
    logic [WIDTH-1:0]       r_mem_wdata, w_mem_wdata_next;
    logic [WIDTH-1:0]       r_rdata, w_rdata_next;
    logic [WIDTH-1:0]       w_rd_sext, w_wr_repl;
    logic [LANES-1:0]       w_wr_be;

`ifdef MEM_ACCESS_INDIRECT_EN
    logic [WIDTH-1:0]       r_wdata;
    logic [ADDR_WIDTH-1:0]  w_ptr;

    assign w_ptr = ADDR_WIDTH'(mem_rdata) & ~LANE_MASK;
`endif

    byte_lane #(.WIDTH(WIDTH)) u_byte_lane (
        .i_rd_word (mem_rdata),
        .i_rd_lane (r_lane),
        .i_wr_byte (req_wdata[7:0]),
        .i_wr_lane (req_addr[LW-1:0]),
        .o_rd_sext (w_rd_sext),
        .o_wr_repl (w_wr_repl),
        .o_wr_be   (w_wr_be)
    );

    always_comb begin
        w_state_next       = r_state;
        w_op_next          = r_op;
        w_lane_next        = r_lane;
        w_mem_read_next    = 1'b0;
        w_mem_write_next   = 1'b0;
        w_mem_address_next = r_mem_address;
        w_mem_be_next      = r_mem_be;
        w_mem_wdata_next   = r_mem_wdata;
        w_rdata_next       = r_rdata;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_op_next   = req_op;
                    w_lane_next = req_addr[LW-1:0];
                    case (req_op)
                        OP_LDW, OP_LDB: begin
                            w_state_next       = ST_ACCESS;
                            w_mem_read_next    = 1'b1;
                            w_mem_be_next      = ALL_LANES;
                            w_mem_address_next = (req_op == OP_LDW) ? (req_addr & ~LANE_MASK) : req_addr;
                        end
                        OP_STW: begin
                            w_state_next       = ST_ACCESS;
                            w_mem_write_next   = 1'b1;
                            w_mem_be_next      = ALL_LANES;
                            w_mem_address_next = req_addr & ~LANE_MASK;
                            w_mem_wdata_next   = req_wdata;
                        end
                        OP_STB: begin
                            w_state_next       = ST_ACCESS;
                            w_mem_write_next   = 1'b1;
                            w_mem_be_next      = w_wr_be;
                            w_mem_address_next = req_addr;
                            w_mem_wdata_next   = w_wr_repl;
                        end
`ifdef MEM_ACCESS_INDIRECT_EN
                        OP_LDI, OP_STI: begin
                            w_state_next       = ST_IND_RD;
                            w_mem_read_next    = 1'b1;
                            w_mem_be_next      = ALL_LANES;
                            w_mem_address_next = req_addr & ~LANE_MASK;
                        end
`endif
                        default: w_state_next = ST_DONE;
                    endcase
                end
            end
`ifdef MEM_ACCESS_INDIRECT_EN
            // Pointer fetched: the op collapses to a plain word access at the pointer.
            ST_IND_RD: begin
                w_mem_read_next = 1'b1;
                if (mem_resp) begin
                    w_state_next       = ST_ACCESS;
                    w_lane_next        = '0;
                    w_mem_address_next = w_ptr;
                    w_mem_be_next      = ALL_LANES;
                    if (r_op == OP_LDI) begin
                        w_op_next = OP_LDW;
                    end else begin
                        w_op_next        = OP_STW;
                        w_mem_read_next  = 1'b0;
                        w_mem_write_next = 1'b1;
                        w_mem_wdata_next = r_wdata;
                    end
                end
            end
`endif
            ST_ACCESS: begin
                w_mem_read_next  = r_mem_read;
                w_mem_write_next = r_mem_write;
                if (mem_resp) begin
                    w_state_next     = ST_DONE;
                    w_mem_read_next  = 1'b0;
                    w_mem_write_next = 1'b0;
                    if (r_mem_read) begin
                        w_rdata_next = (r_op == OP_LDB) ? w_rd_sext : mem_rdata;
                    end
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_lane        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_be      <= '0;
            r_mem_wdata   <= '0;
            r_rdata       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_op          <= w_op_next;
            r_lane        <= w_lane_next;
            r_busy        <= (w_state_next != ST_IDLE);
            r_done        <= (w_state_next == ST_DONE);
            r_mem_read    <= w_mem_read_next;
            r_mem_write   <= w_mem_write_next;
            r_mem_address <= w_mem_address_next;
            r_mem_be      <= w_mem_be_next;
            r_mem_wdata   <= w_mem_wdata_next;
            r_rdata       <= w_rdata_next;
        end
    end

`ifdef MEM_ACCESS_INDIRECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdata <= '0;
        end else if (r_state == ST_IDLE && req) begin
            r_wdata <= req_wdata;
        end
    end
`endif

    assign busy            = r_busy;
    assign done            = r_done;
    assign rdata           = r_rdata;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_mem_address;
    assign mem_byte_enable = r_mem_be;
    assign mem_wdata       = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (WIDTH 16 and 32 instances)
`timescale 1ns/1ps
module tb_mem_access_unit;
    import lc3b_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req;
    logic [2:0]  req_op;
    logic [15:0] req_addr, req_wdata;
    logic        busy, done;
    logic [15:0] rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_resp;

    logic        req_b;
    logic [2:0]  req_op_b;
    logic [15:0] req_addr_b;
    logic [31:0] req_wdata_b;
    logic        busy_b, done_b;
    logic [31:0] rdata_b;
    logic        mem_read_b, mem_write_b;
    logic [15:0] mem_address_b;
    logic [3:0]  mem_byte_enable_b;
    logic [31:0] mem_wdata_b, mem_rdata_b;
    logic        mem_resp_b;

    mem_access_unit #(.WIDTH(16), .ADDR_WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    mem_access_unit #(.WIDTH(32), .ADDR_WIDTH(16)) u_dut32 (
        .clk(clk), .reset(reset), .req(req_b), .req_op(req_op_b), .req_addr(req_addr_b),
        .req_wdata(req_wdata_b), .busy(busy_b), .done(done_b), .rdata(rdata_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_address(mem_address_b),
        .mem_byte_enable(mem_byte_enable_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .mem_resp(mem_resp_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
    } done_t;

    acc_t        exp_acc_q[$];
    done_t       exp_done_q[$];
    logic [15:0] mem16 [logic [15:0]];
    int          wait_cycles = 0;
    int          wcnt = 0;
    int          cyc = 0;
    logic        late_resp = 1'b0;
    acc_t        a;
    done_t       d;
    logic [15:0] w_word, m_val;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder for the 16-bit unit: checks each new access, then answers after wait_cycles.
    always @(negedge clk) begin
        mem_resp = late_resp;
        if (reset) begin
            wcnt = 0;
        end else if (mem_read || mem_write) begin
            check_eq("rw_excl", 32'(mem_read & mem_write), 32'd0);
            if (wcnt == 0) begin
                check_eq("acc_pending", 32'(exp_acc_q.size() != 0), 32'd1);
                if (exp_acc_q.size() != 0) begin
                    a = exp_acc_q.pop_front();
                    check_eq("acc_dir", 32'(mem_write), 32'(a.wr));
                    check_eq("acc_addr", 32'(mem_address), 32'(a.addr));
                    check_eq("acc_be", 32'(mem_byte_enable), 32'(a.be));
                    if (a.wr) check_eq("acc_wdata", 32'(mem_wdata), 32'(a.wdata));
                end
            end
            if (wcnt == wait_cycles) begin
                mem_resp  = 1'b1;
                w_word    = {mem_address[15:1], 1'b0};
                m_val     = mem16.exists(w_word) ? mem16[w_word] : 16'h0000;
                mem_rdata = m_val;
                if (mem_write) begin
                    if (mem_byte_enable[0]) m_val[7:0]  = mem_wdata[7:0];
                    if (mem_byte_enable[1]) m_val[15:8] = mem_wdata[15:8];
                    mem16[w_word] = m_val;
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && done) begin
            check_eq("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
            if (exp_done_q.size() != 0) begin
                d = exp_done_q.pop_front();
                check_eq("rdata", 32'(rdata), 32'(d.rdata));
                check_eq("latency_cyc", 32'(cyc), 32'(d.cyc));
            end
        end
    end

    always @(negedge clk) begin
        mem_resp_b  = mem_read_b | mem_write_b;
        mem_rdata_b = 32'h8011_2233;
    end

    task automatic push_acc(input logic wr, input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd);
        exp_acc_q.push_back('{wr, addr, be, wd});
    endtask

    task automatic do_op(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                         input int waits, input int lat, input logic [15:0] erd, input bit poke);
        @(negedge clk);
        wait_cycles = waits;
        req = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        exp_done_q.push_back('{erd, cyc + lat});
        @(negedge clk);
        req = 1'b0;
        if (poke) begin
            @(negedge clk);
            req = 1'b1; req_op = OP_STW; req_addr = 16'h0BAD; req_wdata = 16'hDEAD;
            @(negedge clk);
            req = 1'b0;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && exp_done_q.size() == 0) break;
        end
        check_eq("done_drained", 32'(exp_done_q.size()), 32'd0);
        check_eq("acc_drained", 32'(exp_acc_q.size()), 32'd0);
    endtask

    task automatic op32(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [15:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] erd);
        int n;
        @(negedge clk);
        req_b = 1'b1; req_op_b = op; req_addr_b = addr; req_wdata_b = wd;
        @(negedge clk);
        req_b = 1'b0;
        check_eq("w32_addr", 32'(mem_address_b), 32'(ea));
        check_eq("w32_be", 32'(mem_byte_enable_b), 32'(ebe));
        if (op == OP_STB || op == OP_STW) check_eq("w32_wdata", mem_wdata_b, ewd);
        n = 1;
        while (!done_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("w32_latency", 32'(n), 32'd2);
        check_eq("w32_rdata", rdata_b, erd);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        req_b = 1'b0; req_op_b = '0; req_addr_b = '0; req_wdata_b = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        mem16[16'h3000] = 16'hBEEF;
        mem16[16'h4000] = 16'h5003;
        mem16[16'h5002] = 16'h7777;
        mem16[16'h6000] = 16'h2004;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_addr", 32'(mem_address), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_be", 32'(mem_byte_enable), 32'd0);
        reset = 1'b0;

        push_acc(1'b0, 16'h3000, 2'b11, 16'h0);
        do_op(OP_LDW, 16'h3001, 16'h0, 0, 2, 16'hBEEF, 1'b0);
        push_acc(1'b1, 16'h2001, 2'b10, 16'hA5A5);
        do_op(OP_STB, 16'h2001, 16'h12A5, 3, 5, 16'hBEEF, 1'b0);
        push_acc(1'b0, 16'h2001, 2'b11, 16'h0);
        do_op(OP_LDB, 16'h2001, 16'h0, 1, 3, 16'hFFA5, 1'b0);
        push_acc(1'b1, 16'h2002, 2'b11, 16'h1234);
        do_op(OP_STW, 16'h2003, 16'h1234, 0, 2, 16'hFFA5, 1'b0);
        push_acc(1'b0, 16'h2002, 2'b11, 16'h0);
        do_op(OP_LDB, 16'h2002, 16'h0, 0, 2, 16'h0034, 1'b0);
        push_acc(1'b0, 16'h2003, 2'b11, 16'h0);
        do_op(OP_LDB, 16'h2003, 16'h0, 2, 4, 16'h0012, 1'b0);
        do_op(3'd6, 16'h3000, 16'h0, 0, 1, 16'h0012, 1'b0);
        do_op(3'd7, 16'h3000, 16'h0, 0, 1, 16'h0012, 1'b0);
`ifdef MEM_ACCESS_INDIRECT_EN
        push_acc(1'b0, 16'h4000, 2'b11, 16'h0);
        push_acc(1'b0, 16'h5002, 2'b11, 16'h0);
        do_op(OP_LDI, 16'h4001, 16'h0, 0, 3, 16'h7777, 1'b0);
        push_acc(1'b0, 16'h6000, 2'b11, 16'h0);
        push_acc(1'b1, 16'h2004, 2'b11, 16'hCAFE);
        do_op(OP_STI, 16'h6000, 16'hCAFE, 1, 5, 16'h7777, 1'b0);
        push_acc(1'b0, 16'h2004, 2'b11, 16'h0);
        do_op(OP_LDW, 16'h2005, 16'h0, 0, 2, 16'hCAFE, 1'b0);
`else
        do_op(OP_LDI, 16'h4001, 16'h0, 0, 1, 16'h0012, 1'b0);
        do_op(OP_STI, 16'h6000, 16'hCAFE, 1, 1, 16'h0012, 1'b0);
        push_acc(1'b0, 16'h2004, 2'b11, 16'h0);
        do_op(OP_LDW, 16'h2005, 16'h0, 0, 2, 16'h0000, 1'b0);
`endif
        push_acc(1'b0, 16'h3000, 2'b11, 16'h0);
        do_op(OP_LDW, 16'h3000, 16'h0, 4, 6, 16'hBEEF, 1'b1);

        // Abort a load mid-wait, then show a stray response is ignored.
        @(negedge clk);
        wait_cycles = 20;
        push_acc(1'b0, 16'h3000, 2'b11, 16'h0);
        req = 1'b1; req_op = OP_LDW; req_addr = 16'h3001;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_pre_rd", 32'(mem_read), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_strobes", 32'({mem_read, mem_write}), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        late_resp = 1'b1;
        @(posedge clk);
        #1 late_resp = 1'b0;
        check_eq("late_busy", 32'(busy), 32'd0);
        check_eq("late_rd", 32'(mem_read), 32'd0);
        @(posedge clk);
        #1;
        check_eq("late_done", 32'(done), 32'd0);
        push_acc(1'b0, 16'h3000, 2'b11, 16'h0);
        do_op(OP_LDW, 16'h3001, 16'h0, 0, 2, 16'hBEEF, 1'b0);

        op32(OP_LDB, 16'h0103, 32'h0, 16'h0103, 4'hF, 32'h0, 32'hFFFF_FF80);
        op32(OP_LDB, 16'h0101, 32'h0, 16'h0101, 4'hF, 32'h0, 32'h0000_0022);
        op32(OP_LDW, 16'h0103, 32'h0, 16'h0100, 4'hF, 32'h0, 32'h8011_2233);
        op32(OP_STB, 16'h0102, 32'h0000_00A5, 16'h0102, 4'b0100, 32'hA5A5_A5A5, 32'h8011_2233);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
